// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge
// Turns a byte stream from a UART receiver into single register accesses and
// sends the response bytes back through a UART transmitter.
//   Commands: 'W' addr d[MSB]..d[LSB]  -> register write, reply 'K'
//             'R' addr                  -> register read, reply data MSB first
//             anything else             -> reply 'E'
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   rx_valid/rx_ready/rx_data  incoming command bytes (valid/ready handshake)
//   tx_valid/tx_ready/tx_data  outgoing reply bytes (valid/ready handshake)
//   reg_valid/reg_ready      register access request / completion
//   reg_write, reg_addr, reg_wdata, reg_rdata  register access payload
//   busy                     high whenever a command is in progress
module uart_reg_bridge #(
  parameter int DataBytes     = 4,
  parameter int TimeoutCycles = 800000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic [7:0]             rx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   reg_valid,
  input  logic                   reg_ready,
  output logic                   reg_write,
  output logic [7:0]             reg_addr,
  output logic [8*DataBytes-1:0] reg_wdata,
  input  logic [8*DataBytes-1:0] reg_rdata,
  output logic                   busy
);

  localparam int DW   = 8 * DataBytes;
  // A zero timeout still needs a legal (unused) 1-bit counter.
  localparam int TmoW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [TmoW-1:0] TmoLast =
    (TimeoutCycles > 0) ? TmoW'(TimeoutCycles - 1) : '0;
  localparam logic [2:0] LastByte = 3'(DataBytes - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GET_ADDR = 3'd1;
  localparam logic [2:0] GET_DATA = 3'd2;
  localparam logic [2:0] BUS      = 3'd3;
  localparam logic [2:0] REPLY    = 3'd4;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  logic [2:0]      state;
  logic [2:0]      byte_cnt;
  logic [2:0]      tx_left;   // reply bytes still to send after the one on tx_data
  logic [TmoW-1:0] tmo_cnt;
  logic [DW-1:0]   resp;      // remaining read-reply bytes, next one in the top byte

  logic rx_fire, tx_fire, bus_done, tmo_hit;
  logic [DW-1:0] wdata_shifted, resp_shifted, rdata_shifted;

  // Byte shifts collapse to plain loads when the register is a single byte.
  generate
    if (DataBytes == 1) begin : g_one_byte
      assign wdata_shifted = rx_data;
      assign resp_shifted  = '0;
      assign rdata_shifted = '0;
    end else begin : g_multi_byte
      assign wdata_shifted = {reg_wdata[DW-9:0], rx_data};
      assign resp_shifted  = {resp[DW-9:0], 8'h00};
      assign rdata_shifted = {reg_rdata[DW-9:0], 8'h00};
    end
  endgenerate

  assign rx_ready = (state == IDLE) || (state == GET_ADDR) || (state == GET_DATA);
  assign busy     = (state != IDLE);
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;
  assign bus_done = reg_valid && reg_ready;
  // An accepted byte wins over an expiring timeout in the same cycle.
  assign tmo_hit  = (TimeoutCycles > 0) && (tmo_cnt == TmoLast) && !rx_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= 3'd0;
      tx_left   <= 3'd0;
      tmo_cnt   <= '0;
      resp      <= '0;
      reg_valid <= 1'b0;
      reg_write <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (rx_fire) begin
            if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
              reg_write <= (rx_data == CMD_WRITE);
              tmo_cnt   <= '0;
              state     <= GET_ADDR;
            end else begin
              tx_valid <= 1'b1;
              tx_data  <= RSP_ERR;
              tx_left  <= 3'd0;
              state    <= REPLY;
            end
          end
        end
        GET_ADDR: begin
          if (rx_fire) begin
            reg_addr <= rx_data;
            tmo_cnt  <= '0;
            if (reg_write) begin
              byte_cnt <= 3'd0;
              state    <= GET_DATA;
            end else begin
              reg_valid <= 1'b1;
              state     <= BUS;
            end
          end else if (tmo_hit) begin
            state <= IDLE;
          end else if (TimeoutCycles > 0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        GET_DATA: begin
          if (rx_fire) begin
            reg_wdata <= wdata_shifted;
            tmo_cnt   <= '0;
            byte_cnt  <= byte_cnt + 3'd1;
            if (byte_cnt == LastByte) begin
              reg_valid <= 1'b1;
              state     <= BUS;
            end
          end else if (tmo_hit) begin
            state <= IDLE;
          end else if (TimeoutCycles > 0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        BUS: begin
          if (bus_done) begin
            reg_valid <= 1'b0;
            tx_valid  <= 1'b1;
            state     <= REPLY;
            if (reg_write) begin
              tx_data <= RSP_OK;
              tx_left <= 3'd0;
            end else begin
              // First reply byte goes straight out; the rest wait in resp.
              tx_data <= reg_rdata[DW-1 -: 8];
              resp    <= rdata_shifted;
              tx_left <= LastByte;
            end
          end
        end
        REPLY: begin
          if (tx_fire) begin
            if (tx_left == 3'd0) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end else begin
              tx_data <= resp[DW-1 -: 8];
              resp    <= resp_shifted;
              tx_left <= tx_left - 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_reg_bridge.md
UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

Interface
REQ-001 Parameter DataBytes, default 4: register data width in bytes; legal range 1..4.
REQ-002 Parameter TimeoutCycles, default 800000: inter-byte timeout in clk cycles; 0 disables the timeout.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 rx_valid  input  1  a received byte is available from the UART.
REQ-006 rx_ready  output  1  the bridge accepts the byte; transfer occurs when rx_valid and rx_ready are both high on a clk edge.
REQ-007 rx_data  input  8  received byte.
REQ-008 tx_valid  output  1  a response byte is offered to the UART transmitter.
REQ-009 tx_ready  input  1  the transmitter accepts the byte; transfer occurs when tx_valid and tx_ready are both high.
REQ-010 tx_data  output  8  response byte.
REQ-011 reg_valid  output  1  register access request.
REQ-012 reg_ready  input  1  the register target completes the access in this cycle; for reads, reg_rdata is valid in the same cycle.
REQ-013 reg_write  output  1  1 = write, 0 = read; stable while reg_valid is high.
REQ-014 reg_addr  output  8  register address; stable while reg_valid is high.
REQ-015 reg_wdata  output  8*DataBytes  write data; stable while reg_valid is high.
REQ-016 reg_rdata  input  8*DataBytes  read data.
REQ-017 busy  output  1  high in every state except Idle.

Function
REQ-018 Command set:
- Write: 0x57 ('W'), addr, then DataBytes data bytes, MSB first.
- Read: 0x52 ('R'), addr.
REQ-019 FSM states: Idle, GetAddr, GetData, Bus, Reply.
REQ-020 rx_ready is high in Idle, GetAddr and GetData, and low in Bus and Reply; it is decoded from the state only, not from rx_valid.
REQ-021 Idle, byte accepted:
- 0x57 -> GetAddr with reg_write=1.
- 0x52 -> GetAddr with reg_write=0.
- Any other byte -> Reply with a single 0x45 ('E') queued.
REQ-022 GetAddr, byte accepted: reg_addr is loaded; a write goes to GetData with the byte counter cleared; a read goes to Bus.
REQ-023 GetData, byte accepted: the byte shifts into reg_wdata from the LSB end, so the first byte ends up MSB; after the DataBytes-th byte the FSM goes to Bus.
REQ-024 Bus: reg_valid is asserted on the first cycle in Bus and held until reg_ready. On the reg_ready cycle reg_valid drops on the next edge, read data is captured into the response register, and the FSM goes to Reply. reg_ready is ignored whenever reg_valid is low.
REQ-025 Reply content:
- Read: DataBytes bytes of the captured data, MSB first.
- Write: a single 0x4B ('K').
- Error: a single 0x45.
REQ-026 Reply handshake: tx_valid and tx_data are registered. tx_valid rises on the first Reply cycle and stays high until the last byte is accepted. tx_data changes only on the edge after an accepting cycle. After the last tx handshake, tx_valid goes low and the FSM returns to Idle on the same edge.
REQ-027 Timeout, TimeoutCycles>0:
- A counter runs in GetAddr and GetData.
- It clears on entry to those states and on every accepted byte.
- When it reaches TimeoutCycles-1 with no byte accepted in that cycle, the FSM returns to Idle with no reg access and no reply.
- An accepted byte in the same cycle takes priority over the timeout.
REQ-028 Counter widths: the timeout counter is clog2(TimeoutCycles+1) bits and never wraps; the byte counter is 3 bits.
REQ-029 Minimum turnaround: a write with DataBytes=4 and zero-wait handshakes completes in 6 accepted rx bytes, 1 Bus cycle and 1 tx byte; the next command byte is accepted no earlier than the cycle after the reply handshake.

Reset
REQ-030 While rst is high, on each clk edge:
- FSM = Idle.
- reg_valid, tx_valid, busy = 0.
- reg_write = 0, reg_addr = 0, reg_wdata = 0, tx_data = 0.
- Byte and timeout counters = 0.
- rx_ready = 1.
REQ-031 Reset asserted mid-command, including during Bus or Reply, aborts immediately. The partial command is discarded and no further reg_valid or tx_valid is produced for it.

Verification
REQ-032 Write, DataBytes=4: rx 57 10 DE AD BE EF, reg_ready=1 -> one reg_valid cycle with reg_write=1, addr 0x10, wdata 0xDEADBEEF; then tx 4B; busy falls after the tx handshake.
REQ-033 Read: rx 52 22, reg_ready held low 3 cycles with rdata=0x12345678 when ready -> reg_valid high 4 cycles with addr and write stable; tx 12 34 56 78 in order.
REQ-034 Backpressure: during a read reply, tx_ready toggles 1,0,0,1,... -> each byte is held stable while tx_valid=1 and tx_ready=0; no byte is lost or duplicated; rx_ready=0 throughout the reply.
REQ-035 Bad command: rx 0x41 -> tx 45, no reg_valid, return to Idle; a following 52 05 is processed normally.
REQ-036 Timeout, TimeoutCycles=16: rx 57 10 AA, then no byte for 16 cycles -> Idle, no reg_valid, no tx. A byte arriving exactly on the 16th cycle is accepted instead.
REQ-037 Reset: rst pulsed one cycle while reg_valid is high -> next cycle reg_valid=0, busy=0, rx_ready=1; no reply is sent.
